// File: rtl/dram_burst_ctrl_if.sv
// Row request/response bundle between the compute fabric and the burst controller.
// master = fabric side, slave = controller side.
interface dram_burst_ctrl_if #(
  parameter int ADDRESS_LEN = 16,
  parameter int ROW_WIDTH   = 512
);
  logic                   req_valid;
  logic                   req_ready;
  logic                   req_we;
  logic [ADDRESS_LEN-1:0] req_addr;
  logic [ROW_WIDTH-1:0]   req_wdata;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic                   rsp_we;
  logic                   rsp_err;
  logic [ROW_WIDTH-1:0]   rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_we, rsp_err, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_we, rsp_err, rsp_rdata
  );
endinterface

// File: rtl/dram_burst_ctrl.sv
// Row-level request controller in front of the DRAM model:
// serialises write rows into beats, reassembles read beats, times out hung accesses.
module dram_burst_ctrl #(
  parameter int ADDRESS_LEN        = 16,
  parameter int BURST_ACCESS_WIDTH = 64,
  parameter int BURST_LEN          = 8,
  parameter int ROW_WIDTH          = 512,
  parameter int TIMEOUT_CYCLES     = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  dram_burst_ctrl_if.slave              bus,
  output logic [ADDRESS_LEN-1:0]        dram_addr,
  output logic                          dram_read_en,
  output logic                          dram_write_en,
  output logic [BURST_ACCESS_WIDTH-1:0] dram_wdata,
  input  logic                          dram_ready,
  input  logic                          dram_complete,
  input  logic [BURST_ACCESS_WIDTH-1:0] dram_rdata,
  input  logic                          dram_valid
);

  localparam int BAW = BURST_ACCESS_WIDTH;
  localparam int CW  = $clog2(BURST_LEN + 1);
  localparam int IW  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int TW  = $clog2(TIMEOUT_CYCLES);

  localparam logic [CW-1:0] BL_C    = CW'(BURST_LEN);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  if (ROW_WIDTH != BURST_LEN * BURST_ACCESS_WIDTH) begin : g_bad_row
    $error("ROW_WIDTH must equal BURST_LEN*BURST_ACCESS_WIDTH");
  end

  typedef enum logic [2:0] {
    IDLE,
    WAIT_RDY,
    ISSUE,
    XFER,
    RESP
  } state_t;

  state_t state;

  logic                           we_q;
  logic [BURST_LEN-1:0][BAW-1:0]  wrow;
  logic [BURST_LEN-1:0][BAW-1:0]  rbuf;
  logic [BURST_LEN-1:0][BAW-1:0]  rbuf_nxt;
  logic [CW-1:0]                  beat_cnt;
  logic [TW-1:0]                  timer;
  logic [IW-1:0]                  beat_idx;
  logic                           beat_hit;

  assign beat_idx = beat_cnt[IW-1:0];
  assign beat_hit = dram_valid && (beat_cnt < BL_C);

  // Merge the beat arriving this cycle so a beat coinciding
  // with dram_complete still lands in the response row.
  always_comb begin
    rbuf_nxt = rbuf;
    if (beat_hit && !we_q) rbuf_nxt[beat_idx] = dram_rdata;
  end

  assign dram_wdata = (beat_cnt < BL_C) ? wrow[beat_idx] : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      bus.req_ready <= 1'b1;
      bus.rsp_valid <= 1'b0;
      bus.rsp_err   <= 1'b0;
      bus.rsp_we    <= 1'b0;
      bus.rsp_rdata <= '0;
      dram_read_en  <= 1'b0;
      dram_write_en <= 1'b0;
      dram_addr     <= '0;
      we_q          <= 1'b0;
      wrow          <= '0;
      rbuf          <= '0;
      beat_cnt      <= '0;
      timer         <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.req_valid) begin
            dram_addr     <= bus.req_addr;
            we_q          <= bus.req_we;
            wrow          <= bus.req_wdata;
            rbuf          <= '0;
            beat_cnt      <= '0;
            bus.req_ready <= 1'b0;
            state         <= WAIT_RDY;
          end
        end
        WAIT_RDY: begin
          if (dram_ready) begin
            dram_read_en  <= !we_q;
            dram_write_en <= we_q;
            timer         <= '0;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          timer <= timer + 1'b1;
          state <= XFER;
        end
        XFER: begin
          if (beat_hit) begin
            rbuf     <= rbuf_nxt;
            beat_cnt <= beat_cnt + 1'b1;
          end
          // Completion takes priority over a coincident timeout.
          if (dram_complete) begin
            dram_read_en  <= 1'b0;
            dram_write_en <= 1'b0;
            bus.rsp_valid <= 1'b1;
            bus.rsp_err   <= 1'b0;
            bus.rsp_we    <= we_q;
            bus.rsp_rdata <= we_q ? '0 : rbuf_nxt;
            state         <= RESP;
          end else if (timer >= TO_LAST) begin
            dram_read_en  <= 1'b0;
            dram_write_en <= 1'b0;
            bus.rsp_valid <= 1'b1;
            bus.rsp_err   <= 1'b1;
            bus.rsp_we    <= we_q;
            bus.rsp_rdata <= '0;
            state         <= RESP;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            bus.req_ready <= 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dram_burst_ctrl.sv
// Scoreboard bench for dram_burst_ctrl with a small behavioural DRAM.
// Stimulus pushes expected responses; a negedge monitor pops and compares.
module tb_dram_burst_ctrl;

  localparam int AL  = 16;
  localparam int BAW = 64;
  localparam int BL  = 8;
  localparam int RW  = 512;
  localparam int TO  = 16;

  typedef struct {
    logic          we;
    logic          err;
    logic [RW-1:0] rdata;
  } exp_t;

  logic           clk;
  logic           rst;
  logic [AL-1:0]  dram_addr;
  logic           dram_read_en;
  logic           dram_write_en;
  logic [BAW-1:0] dram_wdata;
  logic           dram_ready;
  logic           dram_complete;
  logic [BAW-1:0] dram_rdata;
  logic           dram_valid;

  dram_burst_ctrl_if #(.ADDRESS_LEN(AL), .ROW_WIDTH(RW)) bus ();

  dram_burst_ctrl #(
    .ADDRESS_LEN(AL),
    .BURST_ACCESS_WIDTH(BAW),
    .BURST_LEN(BL),
    .ROW_WIDTH(RW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .dram_addr(dram_addr),
    .dram_read_en(dram_read_en),
    .dram_write_en(dram_write_en),
    .dram_wdata(dram_wdata),
    .dram_ready(dram_ready),
    .dram_complete(dram_complete),
    .dram_rdata(dram_rdata),
    .dram_valid(dram_valid)
  );

  int   n_vec = 0;
  int   n_bad = 0;
  exp_t sbq[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [RW-1:0] act,
                     input logic [RW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [RW-1:0] mk_row(input logic [BAW-1:0] base,
                                           input logic [BAW-1:0] step);
    logic [RW-1:0] r;
    r = '0;
    for (int i = 0; i < BL; i++) r[i*BAW +: BAW] = base + step * BAW'(i);
    return r;
  endfunction

  // Behavioural DRAM: one cycle of latency after the enable,
  // then BL beats with dram_complete on the last one.
  logic [BAW-1:0] mem [32][BL];
  logic           busy;
  logic           ready_ctl;
  logic           hang;
  logic           wr;
  logic [4:0]     ma;
  int             en_cycles;
  int             beat_no;
  logic [AL-1:0]  seen_addr;

  assign dram_ready = ready_ctl && !busy;

  always begin
    @(negedge clk);
    dram_valid    = 1'b0;
    dram_complete = 1'b0;
    if (rst && (dram_read_en || dram_write_en) && !busy) begin
      busy      = 1'b1;
      seen_addr = dram_addr;
      ma        = dram_addr[4:0];
      wr        = dram_write_en;
      en_cycles = 0;
      beat_no   = -1;
      if (hang) begin
        while (rst && (dram_read_en || dram_write_en)) begin
          en_cycles++;
          @(negedge clk);
        end
      end else begin
        @(negedge clk);
        for (int i = 0; i < BL && rst; i++) begin
          beat_no       = i;
          dram_valid    = 1'b1;
          dram_complete = (i == BL - 1);
          if (wr) mem[ma][i] = dram_wdata;
          else dram_rdata = mem[ma][i];
          @(negedge clk);
        end
        dram_valid    = 1'b0;
        dram_complete = 1'b0;
      end
      busy = 1'b0;
    end
  end

  always begin
    @(negedge clk);
    #2;
    if (rst && bus.rsp_valid && bus.rsp_ready) begin
      if (sbq.size() == 0) begin
        chk("unexpected_rsp", 1'b1, 1'b0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("rsp_we", bus.rsp_we, e.we);
        chk("rsp_err", bus.rsp_err, e.err);
        chk("rsp_rdata", bus.rsp_rdata, e.rdata);
      end
    end
  end

  task automatic do_req(input logic we, input logic [AL-1:0] addr,
                        input logic [RW-1:0] wdata, input bit push,
                        input logic err, input logic [RW-1:0] rdata);
    exp_t e;
    int   t;
    t = 0;
    while (!bus.req_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("req_ready_wait", bus.req_ready, 1'b1);
    if (push) begin
      e.we    = we;
      e.err   = err;
      e.rdata = rdata;
      sbq.push_back(e);
    end
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    for (int i = 0; i < 200 && sbq.size() != 0; i++) @(negedge clk);
    chk("rsp_arrived", 32'(sbq.size()), 0);
    @(negedge clk);
  endtask

  logic [RW-1:0] row1, row2, row3;
  logic          en_any;
  int            t;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    row1 = mk_row(64'h11, 64'h11);
    row2 = mk_row(64'hA5A5_0000_0000_0000, 64'h1);
    row3 = mk_row(64'hDEAD_BEEF_0000_0100, 64'h100);
    for (int a = 0; a < 32; a++)
      for (int i = 0; i < BL; i++) mem[a][i] = '0;
    for (int i = 0; i < BL; i++) mem[3][i] = row2[i*BAW +: BAW];
    busy          = 1'b0;
    ready_ctl     = 1'b1;
    hang          = 1'b0;
    beat_no       = -1;
    en_cycles     = 0;
    dram_valid    = 1'b0;
    dram_complete = 1'b0;
    dram_rdata    = '0;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b1;
    rst           = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    chk("rst_req_ready", bus.req_ready, 1'b1);
    chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
    chk("rst_rsp_rdata", bus.rsp_rdata, '0);
    chk("rst_enables", {dram_read_en, dram_write_en}, 2'b00);
    chk("rst_dram_addr", dram_addr, '0);
    chk("rst_dram_wdata", dram_wdata, '0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Write row 0x11..0x88 to address 5.
    do_req(1'b1, 16'd5, row1, 1'b1, 1'b0, '0);
    wait_rsp();
    chk("t1_addr", seen_addr, 16'd5);
    for (int i = 0; i < BL; i++)
      chk($sformatf("t1_beat%0d", i), mem[5][i], 64'h11 * (i + 1));

    // Read it back, then a preloaded row.
    do_req(1'b0, 16'd5, '0, 1'b1, 1'b0, row1);
    wait_rsp();
    do_req(1'b0, 16'd3, '0, 1'b1, 1'b0, row2);
    wait_rsp();

    // DRAM busy for 10 cycles after accept.
    ready_ctl = 1'b0;
    do_req(1'b1, 16'd10, row3, 1'b1, 1'b0, '0);
    en_any = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #2;
      en_any = en_any | dram_read_en | dram_write_en;
    end
    chk("t5_no_en_while_busy", en_any, 1'b0);
    ready_ctl = 1'b1;
    @(negedge clk);
    #2;
    chk("t5_issue_next", {dram_read_en, dram_write_en}, 2'b01);
    wait_rsp();
    for (int i = 0; i < BL; i++)
      chk($sformatf("t5_beat%0d", i), mem[10][i],
          64'hDEAD_BEEF_0000_0100 + 64'h100 * i);

    // Response backpressure with a competing request held on the bus.
    bus.rsp_ready = 1'b0;
    do_req(1'b0, 16'd5, '0, 1'b1, 1'b0, row1);
    t = 0;
    while (!bus.rsp_valid && t < 100) begin
      @(negedge clk);
      #2;
      t++;
    end
    chk("t4_rsp_valid_seen", bus.rsp_valid, 1'b1);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 16'd9;
    bus.req_wdata = row2;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #2;
      chk("t4_hold_valid", bus.rsp_valid, 1'b1);
      chk("t4_hold_rdata", bus.rsp_rdata, row1);
      chk("t4_req_ready", bus.req_ready, 1'b0);
      chk("t4_no_en", {dram_read_en, dram_write_en}, 2'b00);
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    wait_rsp();

    // DRAM never completes: timeout after TO cycles of enable.
    hang = 1'b1;
    do_req(1'b0, 16'd2, '0, 1'b1, 1'b1, '0);
    wait_rsp();
    @(negedge clk);
    chk("t3_en_cycles", 32'(en_cycles), 32'd16);
    hang = 1'b0;

    // Reset in the middle of a write burst.
    do_req(1'b1, 16'd7, row3, 1'b0, 1'b0, '0);
    t = 0;
    while (beat_no != 3 && t < 50) begin
      @(negedge clk);
      #2;
      t++;
    end
    chk("t6_reached_beat3", 32'(beat_no), 32'd3);
    rst = 1'b0;
    #1;
    chk("t6_en_drop", {dram_read_en, dram_write_en}, 2'b00);
    chk("t6_rsp_valid", bus.rsp_valid, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #2;
    chk("t6_req_ready", bus.req_ready, 1'b1);
    repeat (3) @(negedge clk);
    chk("t6_no_rsp", bus.rsp_valid, 1'b0);
    chk("sb_empty", 32'(sbq.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
